// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared definitions for the instruction fetch stage:
//     fetch_state_e : fetch controller states (S_REQ=0, S_BUF=1, S_DROP=2)
//     NOP           : instruction word written into IF/ID for a bubble
//     PC_INC        : sequential PC increment
//     PC_ALIGN_MASK : clears the byte-offset bits of a redirect address
//     align_pc()    : word-aligns an address
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_BUF  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP           = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Masking (rather than slicing) keeps every target bit in use.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction memory request/acknowledge bus.
//     req  : request valid (held until ack)
//     addr : word address of the request, stable while req=1 and ack=0
//     ack  : one-cycle completion pulse
//     data : instruction word, valid in the ack cycle
//   Modports: master (fetch stage), slave (instruction memory).
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );

endinterface

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with three controls.
//     clk, rst_n     : clock, asynchronous active-low reset
//     bubble         : load a NOP bubble (valid=0); wins over load
//     load           : load {load_pc_plus4, load_instr} as a real instruction
//     (neither)      : hold the current contents
//     pc_plus4/instr/valid : registered outputs
// -----------------------------------------------------------------------------
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] load_pc_plus4,
  input  logic [31:0] load_instr,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_plus4 <= '0;
      instr    <= NOP;
      valid    <= 1'b0;
    end else if (bubble) begin
      pc_plus4 <= '0;
      instr    <= NOP;
      valid    <= 1'b0;
    end else if (load) begin
      pc_plus4 <= load_pc_plus4;
      instr    <= load_instr;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction fetch stage: keeps one request in flight to instruction memory,
//   parks a returned word in a one-entry buffer when the pipeline stalls, and
//   discards the in-flight response after a branch/jump redirect.
//   Parameters:
//     RESET_PC       : first fetch address after reset
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset
//     pcWrite_i      : PC update enable (0 = stall)
//     IFIDWrite_i    : IF/ID write enable (0 = hold)
//     flush_i        : redirect resolved in ID this cycle
//     branchTarget_i : redirect address (used when flush_i=1)
//     imem           : instruction memory bus (master side)
//     IFIDPCPlus4_o  : address+4 of the instruction held in IF/ID
//     IFIDInstr_o    : instruction held in IF/ID (NOP for a bubble)
//     IFIDValid_o    : 1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   pcWrite_i,
  input  logic                   IFIDWrite_i,
  input  logic                   flush_i,
  input  logic [31:0]            branchTarget_i,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            IFIDPCPlus4_o,
  output logic [31:0]            IFIDInstr_o,
  output logic                   IFIDValid_o
);

  fetch_state_e state, state_next;

  logic [31:0] fetch_pc,  fetch_pc_next;
  logic [31:0] drop_addr, drop_addr_next;
  logic [31:0] buf_pc,    buf_pc_next;
  logic [31:0] buf_instr, buf_instr_next;

  logic        advance;
  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_load_pc_plus4;
  logic [31:0] ifid_load_instr;

  // Both hazard enables must be high for the pipeline to move forward.
  assign advance = pcWrite_i & IFIDWrite_i;

  // Memory bus outputs depend only on registered state, so the address cannot
  // glitch while a request waits for its ack.
  always_comb begin
    imem.req  = (state != S_BUF);
    imem.addr = (state == S_DROP) ? drop_addr : fetch_pc;
  end

  // Next-state logic. A redirect overrides every other event: IF/ID takes a
  // bubble, the buffer is emptied, and the PC jumps to the aligned target. If
  // the current request has not been acked yet, its address moves to
  // drop_addr so the bus stays stable until the stale response comes back.
  always_comb begin
    state_next         = state;
    fetch_pc_next      = fetch_pc;
    drop_addr_next     = drop_addr;
    buf_pc_next        = buf_pc;
    buf_instr_next     = buf_instr;
    ifid_load          = 1'b0;
    ifid_bubble        = 1'b0;
    ifid_load_pc_plus4 = fetch_pc + PC_INC;
    ifid_load_instr    = imem.data;

    if (flush_i) begin
      ifid_bubble    = 1'b1;
      fetch_pc_next  = align_pc(branchTarget_i);
      buf_pc_next    = '0;
      buf_instr_next = NOP;
      unique case (state)
        S_REQ: begin
          if (imem.ack) begin
            state_next = S_REQ;
          end else begin
            drop_addr_next = fetch_pc;
            state_next     = S_DROP;
          end
        end
        S_BUF: begin
          state_next = S_REQ;
        end
        S_DROP: begin
          state_next = imem.ack ? S_REQ : S_DROP;
        end
        default: begin
          state_next = S_REQ;
        end
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem.ack) begin
            if (advance) begin
              ifid_load     = 1'b1;
              fetch_pc_next = fetch_pc + PC_INC;
            end else begin
              // Park the word; fetch_pc stays on its address until it issues.
              buf_pc_next    = fetch_pc;
              buf_instr_next = imem.data;
              state_next     = S_BUF;
            end
          end else begin
            ifid_bubble = IFIDWrite_i;
          end
        end
        S_BUF: begin
          if (advance) begin
            ifid_load          = 1'b1;
            ifid_load_pc_plus4 = buf_pc + PC_INC;
            ifid_load_instr    = buf_instr;
            fetch_pc_next      = fetch_pc + PC_INC;
            state_next         = S_REQ;
          end
        end
        S_DROP: begin
          ifid_bubble = IFIDWrite_i;
          if (imem.ack) begin
            state_next = S_REQ;
          end
        end
        default: begin
          state_next = S_REQ;
        end
      endcase
    end
  end

  // Controller state, PC and buffer registers. Reset drops any request that
  // was in flight; the memory shares the same reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
      buf_pc    <= '0;
      buf_instr <= NOP;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      drop_addr <= drop_addr_next;
      buf_pc    <= buf_pc_next;
      buf_instr <= buf_instr_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk           (clk_i),
    .rst_n         (rst_n_i),
    .load          (ifid_load),
    .bubble        (ifid_bubble),
    .load_pc_plus4 (ifid_load_pc_plus4),
    .load_instr    (ifid_load_instr),
    .pc_plus4      (IFIDPCPlus4_o),
    .instr         (IFIDInstr_o),
    .valid         (IFIDValid_o)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Self-checking bench for if_fetch_stage. A memory model with configurable
//   latency answers requests; a reference model holds the program-order
//   instruction stream (sequential from RESET_PC, restarted at every redirect)
//   in a queue, and a monitor pops and compares each delivered instruction.
//   A second instance with RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        flush;
  logic [31:0] target;

  logic [31:0] pc4;
  logic [31:0] instr;
  logic        valid;
  logic [31:0] pc4_2;
  logic [31:0] instr_2;
  logic        valid_2;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  int mem_lat = 0;
  bit rand_lat = 1'b0;
  logic        ack_raw;
  logic [31:0] data_raw;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;

  if_fetch_stage_if imem ();
  if_fetch_stage_if imem2 ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pcWrite_i      (pc_write),
    .IFIDWrite_i    (ifid_write),
    .flush_i        (flush),
    .branchTarget_i (target),
    .imem           (imem),
    .IFIDPCPlus4_o  (pc4),
    .IFIDInstr_o    (instr),
    .IFIDValid_o    (valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .pcWrite_i      (1'b1),
    .IFIDWrite_i    (1'b1),
    .flush_i        (1'b0),
    .branchTarget_i (32'h0),
    .imem           (imem2),
    .IFIDPCPlus4_o  (pc4_2),
    .IFIDInstr_o    (instr_2),
    .IFIDValid_o    (valid_2)
  );

  // Memory contents: a nonzero word derived from the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // Zero-wait memory for the wrap-around instance.
  assign imem2.ack  = imem2.req;
  assign imem2.data = instr_of(imem2.addr);

  // Main memory shares the DUT reset, so an ack never lands during reset.
  assign imem.ack  = ack_raw & rst_n;
  assign imem.data = data_raw;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, got no response, expected one", name);
  endtask

  // Memory model: answers each request after 'latency' wait cycles, checks
  // the address stays put while the request waits, and that a request is
  // never withdrawn before its ack.
  initial begin : memory_model
    bit          busy;
    int          cnt;
    int          cur_lat;
    logic [31:0] req_addr;
    busy = 1'b0; cnt = 0; cur_lat = 0; req_addr = '0;
    ack_raw = 1'b0; data_raw = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; cnt = 0; ack_raw = 1'b0;
      end else if (imem.req) begin
        if (!busy) begin
          busy     = 1'b1;
          cnt      = 0;
          req_addr = imem.addr;
          cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
        end else begin
          checkOutput("addr_stable", imem.addr, req_addr);
        end
        if (cnt >= cur_lat) begin
          ack_raw  = 1'b1;
          data_raw = instr_of(req_addr);
          busy     = 1'b0;
        end else begin
          ack_raw = 1'b0;
          cnt++;
        end
      end else begin
        if (busy) checkOutput("req_held", 32'(imem.req), 32'd1);
        ack_raw = 1'b0;
        busy    = 1'b0;
      end
    end
  end

  task automatic model_refill();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.pc4   = next_pc + 32'd4;
      e.instr = instr_of(next_pc);
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Monitor: after every edge, a redirect must produce a bubble and restart
  // the expected stream; an advancing edge that shows a valid instruction
  // must deliver exactly the next program-order word; a held IF/ID must not
  // change.
  initial begin : monitor
    logic        s_rst, s_flush, s_pcw, s_ifw;
    logic [31:0] s_tgt;
    logic [31:0] prev_pc4, prev_instr;
    logic        prev_valid;
    exp_t        e;
    prev_pc4 = '0; prev_instr = '0; prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_flush = flush; s_pcw = pc_write; s_ifw = ifid_write;
      s_tgt = target;
      #1;
      if (!s_rst) begin
        exp_q.delete();
        next_pc = 32'h0;
        model_refill();
        prev_pc4 = '0; prev_instr = '0; prev_valid = 1'b0;
      end else begin
        if (s_flush) begin
          checkOutput("flush_valid", 32'(valid), 32'd0);
          checkOutput("flush_instr", instr, 32'h0);
          exp_q.delete();
          next_pc = s_tgt & 32'hFFFF_FFFC;
          model_refill();
        end else if (s_pcw && s_ifw) begin
          if (valid) begin
            e = exp_q.pop_front();
            checkOutput("deliver_pc4", pc4, e.pc4);
            checkOutput("deliver_instr", instr, e.instr);
            delivered++;
            model_refill();
          end else begin
            checkOutput("bubble_instr", instr, 32'h0);
          end
        end else if (!s_ifw) begin
          checkOutput("hold_pc4", pc4, prev_pc4);
          checkOutput("hold_instr", instr, prev_instr);
          checkOutput("hold_valid", 32'(valid), 32'(prev_valid));
        end else if (!valid) begin
          checkOutput("bubble_instr", instr, 32'h0);
        end
        prev_pc4 = pc4; prev_instr = instr; prev_valid = valid;
      end
    end
  end

  task automatic applyStimulus(input logic pcw, input logic ifw, input logic fl,
                               input logic [31:0] tgt);
    @(negedge clk);
    pc_write   = pcw;
    ifid_write = ifw;
    flush      = fl;
    target     = tgt;
  endtask

  // Drive one cycle and land just after the edge that consumes it.
  task automatic step(input logic pcw, input logic ifw, input logic fl,
                      input logic [31:0] tgt);
    applyStimulus(pcw, ifw, fl, tgt);
    @(posedge clk);
    #2;
  endtask

  // Reset asserted mid-cycle (outputs must clear at once) and released
  // mid-cycle; the first request must then be at RESET_PC.
  task automatic applyReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; flush = 1'b0; target = '0;
    #1;
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_pc4", pc4, 32'h0);
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_req", 32'(imem.req), 32'd1);
    checkOutput("reset_addr", imem.addr, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("first_req", 32'(imem.req), 32'd1);
    checkOutput("first_addr", imem.addr, 32'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit found;
    int start_delivered;
    rst_n = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; flush = 1'b0; target = '0;

    // Zero-wait memory, no stalls: IF/ID fills with 4, 8, 12.
    mem_lat = 0; rand_lat = 1'b0;
    applyReset();
    checkOutput("wrap_first_addr", imem2.addr, 32'hFFFF_FFFC);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("seq_pc4", pc4, 32'(4 * i));
      checkOutput("seq_valid", 32'(valid), 32'd1);
      checkOutput("seq_instr", instr, instr_of(32'(4 * (i - 1))));
      if (i == 1) begin
        checkOutput("wrap_second_addr", imem2.addr, 32'h0);
        checkOutput("wrap_pc4", pc4_2, 32'h0);
        checkOutput("wrap_instr", instr_2, instr_of(32'hFFFF_FFFC));
        checkOutput("wrap_valid", 32'(valid_2), 32'd1);
      end
    end

    // Ack at address 8 under a 3-cycle stall: word parked, no request,
    // IF/ID held, then the parked word is delivered.
    applyReset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_req", 32'(imem.req), 32'd0);
      checkOutput("stall_pc4", pc4, 32'd8);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("buf_pc4", pc4, 32'd12);
    checkOutput("buf_instr", instr, instr_of(32'd8));
    checkOutput("buf_valid", 32'(valid), 32'd1);
    checkOutput("buf_next_addr", imem.addr, 32'd12);

    // Latency 3, redirect to 0x100 while 0x10 is outstanding.
    mem_lat = 3;
    applyReset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (valid && pc4 == 32'd16) found = 1'b1;
    end
    if (!found) reportTimeout("reach_0x10");
    step(1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("drop_addr", imem.addr, 32'h10);
    checkOutput("drop_req", 32'(imem.req), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("drop_addr", imem.addr, 32'h10);
      checkOutput("drop_valid", 32'(valid), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redirect_addr", imem.addr, 32'h100);
    checkOutput("redirect_valid", 32'(valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (valid) found = 1'b1;
    end
    if (!found) reportTimeout("target_fetch");
    checkOutput("target_pc4", pc4, 32'h104);
    checkOutput("target_instr", instr, instr_of(32'h100));

    // Redirect together with a stall while a word is parked.
    mem_lat = 0;
    applyReset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("park_req", 32'(imem.req), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h203);
    checkOutput("fs_valid", 32'(valid), 32'd0);
    checkOutput("fs_instr", instr, 32'h0);
    checkOutput("fs_req", 32'(imem.req), 32'd1);
    checkOutput("fs_addr", imem.addr, 32'h200);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("fs_pc4", pc4, 32'h204);
    checkOutput("fs_deliver", instr, instr_of(32'h200));

    // Reset pulse while discarding a stale response.
    mem_lat = 3;
    applyReset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (valid) found = 1'b1;
    end
    if (!found) reportTimeout("rd_first");
    step(1'b1, 1'b1, 1'b1, 32'h300);
    checkOutput("rd_drop_addr", imem.addr, 32'h4);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rd_valid", 32'(valid), 32'd0);
    checkOutput("rd_pc4", pc4, 32'h0);
    checkOutput("rd_instr", instr, 32'h0);
    checkOutput("rd_addr", imem.addr, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rd_restart_addr", imem.addr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (valid) found = 1'b1;
    end
    if (!found) reportTimeout("rd_restart");
    checkOutput("rd_restart_pc4", pc4, 32'h4);
    checkOutput("rd_restart_instr", instr, instr_of(32'h0));

    // Random stalls, redirects and memory latency against the model.
    rand_lat = 1'b1;
    applyReset();
    start_delivered = delivered;
    repeat (800) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 11) == 0, $urandom);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (delivered - start_delivered < 60) begin
      errors++;
      $display("[TB] FAIL random_progress: got %0d delivered, expected at least 60",
               delivered - start_delivered);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
